fifo_wr_packer: RTL and testbench

Write-side front end for the clock-domain-crossing FIFO: accepts a narrow valid/ready byte stream in the write clock domain and packs PACK beats into one FIFO word. Each word carries a last flag and a lane count. The block drives the FIFO write port (`wr_en`/`wr_data`/`full`) and is the producer counterpart of the first-word-fall-through reader on the far side. Single clock, one output holding register, no combinational path from `in_valid` to `in_ready`.

---
 rtl/fifo_wr_packer_if.sv | 33 +++
 rtl/fifo_wr_packer.sv | 110 +++++++++++
 tb/tb_fifo_wr_packer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_packer_if.sv
// fifo_wr_packer_if: bundles the byte-stream input handshake and the FIFO
// write port of the write-side packer.
//   in_valid/in_ready/in_data/in_last : narrow input beat stream
//   flush                             : single-cycle request to close a partial word
//   fifo_full/fifo_wr_en/fifo_wr_data : write port of the clock-crossing FIFO
// modport slave  : the packer (consumes beats, drives the FIFO write port)
// modport master : the environment (beat source plus FIFO full status)
interface fifo_wr_packer_if #(
  parameter int IN_WIDTH = 8,
  parameter int PACK     = 4
);
  localparam int CW        = $clog2(PACK);
  localparam int OUT_WIDTH = IN_WIDTH * PACK + CW + 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_last;
  logic                 flush;
  logic                 fifo_full;
  logic                 fifo_wr_en;
  logic [OUT_WIDTH-1:0] fifo_wr_data;

  modport master (
    output in_valid, in_data, in_last, flush, fifo_full,
    input  in_ready, fifo_wr_en, fifo_wr_data
  );

  modport slave (
    input  in_valid, in_data, in_last, flush, fifo_full,
    output in_ready, fifo_wr_en, fifo_wr_data
  );
endinterface

// File: rtl/fifo_wr_packer.sv
// fifo_wr_packer: write-side front end of the clock-crossing FIFO. Packs PACK
// narrow beats into one FIFO word {last, cnt_m1, lanes}; lane 0 holds the
// first beat and unused lanes read zero. One output holding register sits
// between the accumulator and the FIFO write port.
// Ports:
//   wr_clk : write-domain clock
//   rst    : synchronous active-high reset
//   bus    : fifo_wr_packer_if.slave (input stream, flush, FIFO write port)
module fifo_wr_packer #(
  parameter int IN_WIDTH = 8,
  parameter int PACK     = 4
) (
  input  logic           wr_clk,
  input  logic           rst,
  fifo_wr_packer_if.slave bus
);
  localparam int CW        = $clog2(PACK);
  localparam int LANES_W   = IN_WIDTH * PACK;
  localparam int OUT_WIDTH = LANES_W + CW + 1;

  // Accumulator and output holding register
  logic [LANES_W-1:0]   lanes;
  logic [CW-1:0]        idx;
  logic                 flush_pend;
  logic                 pend_valid;
  logic [OUT_WIDTH-1:0] pend_word;

  logic [LANES_W-1:0]   lanes_nxt;
  logic [CW-1:0]        idx_nxt;
  logic                 flush_pend_nxt;
  logic                 pend_valid_nxt;
  logic [OUT_WIDTH-1:0] pend_word_nxt;

  logic                 ready;
  logic                 wr_en;
  logic                 accept;
  logic                 flush_any;
  logic                 close_beat;
  logic [LANES_W-1:0]   lanes_beat;

  function automatic logic [OUT_WIDTH-1:0] pack_word(
    input logic               last,
    input logic [CW-1:0]      cnt_m1,
    input logic [LANES_W-1:0] l
  );
    pack_word = {last, cnt_m1, l};
  endfunction

  always_comb begin
    // The holding register is free, or is being written to the FIFO this
    // cycle; only registered state and fifo_full feed in_ready.
    ready      = ~pend_valid | ~bus.fifo_full;
    wr_en      = pend_valid & ~bus.fifo_full;
    accept     = bus.in_valid & ready;
    flush_any  = flush_pend | bus.flush;

    lanes_beat = lanes;
    lanes_beat[idx*IN_WIDTH +: IN_WIDTH] = bus.in_data;

    close_beat = accept & ((idx == CW'(PACK - 1)) | bus.in_last);

    lanes_nxt      = lanes;
    idx_nxt        = idx;
    flush_pend_nxt = flush_any;
    pend_valid_nxt = pend_valid & ~wr_en;
    pend_word_nxt  = pend_word;

    if (accept) begin
      // A flush arriving with a beat stays pending and applies afterwards.
      if (close_beat) begin
        pend_valid_nxt = 1'b1;
        pend_word_nxt  = pack_word(bus.in_last, idx, lanes_beat);
        idx_nxt        = '0;
        lanes_nxt      = '0;
      end else begin
        idx_nxt   = idx + CW'(1);
        lanes_nxt = lanes_beat;
      end
    end else if (ready && flush_any) begin
      flush_pend_nxt = 1'b0;
      // An empty accumulator simply swallows the flush.
      if (idx != '0) begin
        pend_valid_nxt = 1'b1;
        pend_word_nxt  = pack_word(1'b0, idx - CW'(1), lanes);
        idx_nxt        = '0;
        lanes_nxt      = '0;
      end
    end
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      lanes      <= '0;
      idx        <= '0;
      flush_pend <= 1'b0;
      pend_valid <= 1'b0;
      pend_word  <= '0;
    end else begin
      lanes      <= lanes_nxt;
      idx        <= idx_nxt;
      flush_pend <= flush_pend_nxt;
      pend_valid <= pend_valid_nxt;
      pend_word  <= pend_word_nxt;
    end
  end

  assign bus.in_ready     = ready;
  assign bus.fifo_wr_en   = wr_en;
  assign bus.fifo_wr_data = pend_word;
endmodule

// File: tb/tb_fifo_wr_packer.sv
// tb_fifo_wr_packer: scenario-task bench for fifo_wr_packer. Expected FIFO
// words are queued when the stimulus is issued and compared in order when
// the packer writes them.
module tb_fifo_wr_packer;
  localparam int IN_WIDTH  = 8;
  localparam int PACK      = 4;
  localparam int OUT_WIDTH = 35;

  logic wr_clk = 1'b0;
  logic rst    = 1'b1;
  always #5 wr_clk = ~wr_clk;

  fifo_wr_packer_if #(.IN_WIDTH(IN_WIDTH), .PACK(PACK)) bus ();

  fifo_wr_packer #(.IN_WIDTH(IN_WIDTH), .PACK(PACK)) dut (
    .wr_clk (wr_clk),
    .rst    (rst),
    .bus    (bus.slave)
  );

  int compared   = 0;
  int mismatched = 0;
  int writes     = 0;
  int cyc        = 0;
  logic [OUT_WIDTH-1:0] exp_q[$];

  always @(posedge wr_clk) cyc <= cyc + 1;

  task automatic idle(input int n);
    repeat (n) @(posedge wr_clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last, input logic fl);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.flush    = fl;
    for (int i = 0; i < 50; i++) begin
      @(negedge wr_clk);
      if (bus.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL beat_timeout: data %h in_ready=%b, required 1 within 50 cycles", d, bus.in_ready);
    end
    @(posedge wr_clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      idle(1);
    end
    compared++;
    if (exp_q.size() !== 0) begin
      mismatched++;
      $display("FAIL %s_drain: %0d words outstanding, required 0", name, exp_q.size());
    end
    idle(3);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge wr_clk);
    @(negedge wr_clk);
    compared++;
    if (bus.fifo_wr_en !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_wr_en: got %b required 0", bus.fifo_wr_en);
    end
    compared++;
    if (bus.fifo_wr_data !== '0) begin
      mismatched++;
      $display("FAIL reset_wr_data: got %h required 0", bus.fifo_wr_data);
    end
    compared++;
    if (bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
    end
    @(posedge wr_clk);
    #1;
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_full_word();
    int c0;
    logic [OUT_WIDTH-1:0] w;
    w = {1'b0, 2'd3, 32'h44332211};
    exp_q.push_back(w);
    c0 = cyc;
    send_beat(8'h11, 1'b0, 1'b0);
    send_beat(8'h22, 1'b0, 1'b0);
    send_beat(8'h33, 1'b0, 1'b0);
    send_beat(8'h44, 1'b0, 1'b0);
    compared++;
    if (cyc - c0 !== 4) begin
      mismatched++;
      $display("FAIL full_word_ready: 4 beats took %0d cycles, required 4", cyc - c0);
    end
    @(negedge wr_clk);
    compared++;
    if (bus.fifo_wr_en !== 1'b1 || bus.fifo_wr_data !== w) begin
      mismatched++;
      $display("FAIL full_word_latency: wr_en=%b data=%h, required 1 %h", bus.fifo_wr_en, bus.fifo_wr_data, w);
    end
    wait_drain("full_word");
  endtask

  task automatic test_last();
    exp_q.push_back({1'b1, 2'd1, 32'h0000BBAA});
    exp_q.push_back({1'b1, 2'd0, 32'h000000CC});
    send_beat(8'hAA, 1'b0, 1'b0);
    send_beat(8'hBB, 1'b1, 1'b0);
    send_beat(8'hCC, 1'b1, 1'b0);
    wait_drain("last");
  endtask

  task automatic test_flush();
    int w0;
    exp_q.push_back({1'b0, 2'd2, 32'h00030201});
    send_beat(8'h01, 1'b0, 1'b0);
    send_beat(8'h02, 1'b0, 1'b0);
    send_beat(8'h03, 1'b0, 1'b0);
    bus.flush = 1'b1;
    idle(1);
    bus.flush = 1'b0;
    wait_drain("flush");
    w0 = writes;
    bus.flush = 1'b1;
    idle(1);
    bus.flush = 1'b0;
    idle(5);
    compared++;
    if (writes !== w0) begin
      mismatched++;
      $display("FAIL flush_empty: %0d writes after empty flush, required 0", writes - w0);
    end
  endtask

  task automatic test_full_stall();
    exp_q.push_back({1'b0, 2'd3, 32'h53525150});
    exp_q.push_back({1'b0, 2'd3, 32'h57565554});
    bus.fifo_full = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) send_beat(8'(8'h50 + i), 1'b0, 1'b0);
      end
      begin
        idle(6);
        @(negedge wr_clk);
        compared++;
        if (bus.in_ready !== 1'b0) begin
          mismatched++;
          $display("FAIL stall_in_ready: got %b required 0", bus.in_ready);
        end
        idle(3);
        bus.fifo_full = 1'b0;
      end
    join
    wait_drain("full_stall");
  endtask

  task automatic test_flush_with_beat();
    exp_q.push_back({1'b0, 2'd1, 32'h00006261});
    send_beat(8'h61, 1'b0, 1'b0);
    send_beat(8'h62, 1'b0, 1'b1);
    wait_drain("flush_with_beat");
  endtask

  task automatic test_reset_mid();
    int w0;
    w0 = writes;
    send_beat(8'h71, 1'b0, 1'b0);
    send_beat(8'h72, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge wr_clk);
    @(negedge wr_clk);
    compared++;
    if (bus.fifo_wr_en !== 1'b0 || bus.fifo_wr_data !== '0 || bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_reset_outputs: wr_en=%b data=%h in_ready=%b, required 0 0 1",
               bus.fifo_wr_en, bus.fifo_wr_data, bus.in_ready);
    end
    @(posedge wr_clk);
    #1;
    rst = 1'b0;
    idle(2);
    compared++;
    if (writes !== w0) begin
      mismatched++;
      $display("FAIL mid_reset_no_write: %0d writes, required 0", writes - w0);
    end
    exp_q.push_back({1'b0, 2'd3, 32'h84838281});
    send_beat(8'h81, 1'b0, 1'b0);
    send_beat(8'h82, 1'b0, 1'b0);
    send_beat(8'h83, 1'b0, 1'b0);
    send_beat(8'h84, 1'b0, 1'b0);
    wait_drain("reset_mid");
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.flush     = 1'b0;
    bus.fifo_full = 1'b0;

    fork
      forever begin
        logic [OUT_WIDTH-1:0] e;
        @(negedge wr_clk);
        if (!rst) begin
          if (bus.fifo_full === 1'b1) begin
            compared++;
            if (bus.fifo_wr_en !== 1'b0) begin
              mismatched++;
              $display("FAIL wr_en_while_full: got %b required 0", bus.fifo_wr_en);
            end
          end
          if (bus.fifo_wr_en === 1'b1) begin
            writes++;
            compared++;
            if (exp_q.size() == 0) begin
              mismatched++;
              $display("FAIL unexpected_write: got %h, required no write", bus.fifo_wr_data);
            end else begin
              e = exp_q.pop_front();
              if (bus.fifo_wr_data !== e) begin
                mismatched++;
                $display("FAIL write_data: got %h required %h", bus.fifo_wr_data, e);
              end
            end
          end
        end
      end
      begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
      end
    join_none

    test_reset();
    test_full_word();
    test_last();
    test_flush();
    test_full_stall();
    test_flush_with_beat();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
